// File: rtl/traffic_ctrl_multi.sv
// ---------------------------------------------------------------------------
// traffic_ctrl_multi
//
// Purpose:
//   Round-robin traffic-light controller for N_DIR approaches. Each approach
//   in turn runs GREEN -> YELLOW -> ALL_RED before the next one is served.
//   Includes a protected left arrow at the start of green, latched
//   pedestrian requests with walk grants, and a tick prescaler so that all
//   phase durations are expressed in ticks of TICK_DIV clock cycles.
//
// Ports:
//   clk        in   1               system clock
//   reset_n    in   1               asynchronous active-low reset
//   i_start    in   1               run enable (level)
//   i_ped_req  in   N_DIR           pedestrian request pulses, one per approach
//   o_ct       out  4*N_DIR         car lamps, approach d: {left,green,yellow,red}
//   o_wt       out  2*N_DIR         walk lamps, approach d: {walk,dont_walk}
//   o_dir      out  $clog2(N_DIR)   approach currently served
//   o_busy     out  1               high whenever the controller is not idle
//
// Configuration:
//   PED_FLASH_EN  when defined, walk flashes during the last FL_TICKS ticks
//                 of a granted green. Otherwise walk is steady and FL_TICKS
//                 has no effect.
// ---------------------------------------------------------------------------
module traffic_ctrl_multi #(
    parameter int N_DIR    = 4,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 8,
    parameter int G_TICKS  = 10,
    parameter int Y_TICKS  = 3,
    parameter int R_TICKS  = 2,
    parameter int L_TICKS  = 2,
    parameter int FL_TICKS = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_start,
    input  logic [N_DIR-1:0]         i_ped_req,
    output logic [4*N_DIR-1:0]       o_ct,
    output logic [2*N_DIR-1:0]       o_wt,
    output logic [$clog2(N_DIR)-1:0] o_dir,
    output logic                     o_busy
);

    localparam int DIR_W = $clog2(N_DIR);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(N_DIR - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(G_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(Y_TICKS - 1);
    localparam logic [CNT_W-1:0] R_LOAD    = CNT_W'(R_TICKS - 1);
    localparam logic [CNT_W-1:0] LEFT_FROM = CNT_W'(G_TICKS - L_TICKS);
    localparam logic [CNT_W-1:0] FL_CNT    = CNT_W'(FL_TICKS);
    // Parity of the first flash-window count value; the walk lamp must be
    // dark on the first flash tick, so walk = parity(first) ^ parity(cnt).
    localparam logic FL_LAST_ODD = (((FL_TICKS - 1) % 2) != 0);

`ifdef PED_FLASH_EN
    localparam logic FLASH_ON = 1'b1;
`else
    localparam logic FLASH_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [DIR_W-1:0]   dir, dir_next;
    logic [PRE_W-1:0]   presc, presc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [N_DIR-1:0]   latch, latch_next;
    logic               grant, grant_next;
    logic               tick;

    logic [4*N_DIR-1:0] ct_next;
    logic [2*N_DIR-1:0] wt_next;
    logic               busy_next;
    logic               left_on;
    logic               walk_on;

    assign tick  = (presc == PRE_LAST);
    assign o_dir = dir;

    // State register. Every output is registered here from its next value,
    // so lamps change on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            dir    <= '0;
            presc  <= '0;
            cnt    <= '0;
            latch  <= '0;
            grant  <= 1'b0;
            o_ct   <= {N_DIR{4'b0001}};
            o_wt   <= {N_DIR{2'b01}};
            o_busy <= 1'b0;
        end else begin
            state  <= state_next;
            dir    <= dir_next;
            presc  <= presc_next;
            cnt    <= cnt_next;
            latch  <= latch_next;
            grant  <= grant_next;
            o_ct   <= ct_next;
            o_wt   <= wt_next;
            o_busy <= busy_next;
        end
    end

    // Next-state logic. The phase counter counts ticks down to zero and the
    // phase advances on the tick that finds it at zero. i_start is only
    // looked at in IDLE and when ALL_RED ends, so it never cuts a phase short.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        presc_next = presc;
        cnt_next   = cnt;
        latch_next = latch | i_ped_req;
        grant_next = grant;

        if (state == IDLE) begin
            presc_next = '0;
            if (i_start) begin
                state_next = GREEN;
                dir_next   = '0;
                cnt_next   = G_LOAD;
            end
        end else begin
            presc_next = tick ? '0 : presc + 1'b1;
            if (tick) begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    case (state)
                        GREEN: begin
                            state_next = YELLOW;
                            cnt_next   = Y_LOAD;
                            grant_next = 1'b0;
                        end
                        YELLOW: begin
                            state_next = ALL_RED;
                            cnt_next   = R_LOAD;
                        end
                        default: begin
                            if (i_start) begin
                                state_next = GREEN;
                                dir_next   = (dir == LAST_DIR) ? '0 : dir + 1'b1;
                                cnt_next   = G_LOAD;
                            end else begin
                                state_next = IDLE;
                                dir_next   = '0;
                                cnt_next   = '0;
                            end
                        end
                    endcase
                end
            end
        end

        // Walk grant is decided once, on green entry. Using the already
        // OR-ed latch means a request on the entry edge itself is honoured;
        // anything arriving later in this green stays latched for next time.
        if ((state_next == GREEN) && (state != GREEN)) begin
            grant_next           = latch_next[dir_next];
            latch_next[dir_next] = 1'b0;
        end
    end

    // Output logic, computed from the next state so the registered lamps
    // line up with the state register.
    always_comb begin
        ct_next   = {N_DIR{4'b0001}};
        wt_next   = {N_DIR{2'b01}};
        busy_next = (state_next != IDLE);
        left_on   = (L_TICKS != 0) && (cnt_next >= LEFT_FROM);
        walk_on   = (FLASH_ON && (cnt_next < FL_CNT)) ? (FL_LAST_ODD ^ cnt_next[0]) : 1'b1;

        for (int d = 0; d < N_DIR; d++) begin
            if (DIR_W'(d) == dir_next) begin
                case (state_next)
                    GREEN: begin
                        ct_next[4*d +: 4] = {left_on, 3'b100};
                        if (grant_next) begin
                            wt_next[2*d +: 2] = {walk_on, 1'b0};
                        end
                    end
                    YELLOW: begin
                        ct_next[4*d +: 4] = 4'b0010;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_traffic_ctrl_multi
//
// Purpose:
//   Self-checking bench for traffic_ctrl_multi with N_DIR=4, TICK_DIV=2,
//   G=10, Y=3, R=2, L=2, FL=3. A reference model that tracks the current
//   phase and the number of cycles spent in it predicts every lamp output,
//   driven by directed sequences followed by randomized start/request traffic.
//   Honours PED_FLASH_EN in its model the same way the design does.
// ---------------------------------------------------------------------------
module tb_traffic_ctrl_multi;

    localparam int N  = 4;
    localparam int TD = 2;
    localparam int G  = 10;
    localparam int Y  = 3;
    localparam int R  = 2;
    localparam int L  = 2;
    localparam int FL = 3;

    logic           clk;
    logic           reset_n;
    logic           i_start;
    logic [N-1:0]   i_ped_req;
    logic [4*N-1:0] o_ct;
    logic [2*N-1:0] o_wt;
    logic [1:0]     o_dir;
    logic           o_busy;

    int checks = 0;
    int errors = 0;

    traffic_ctrl_multi #(
        .N_DIR    (N),
        .TICK_DIV (TD),
        .CNT_W    (8),
        .G_TICKS  (G),
        .Y_TICKS  (Y),
        .R_TICKS  (R),
        .L_TICKS  (L),
        .FL_TICKS (FL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (i_start),
        .i_ped_req (i_ped_req),
        .o_ct      (o_ct),
        .o_wt      (o_wt),
        .o_dir     (o_dir),
        .o_busy    (o_busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which phase we are in, for which approach, how many
    // cycles have elapsed since that phase began, and the pending requests.
    typedef enum int {M_IDLE, M_GREEN, M_YELLOW, M_ALLRED} phase_t;

    phase_t       m_state;
    int           m_dir;
    int           m_el;
    logic         m_grant;
    logic [N-1:0] m_pend;

    function automatic int phaseCycles(input phase_t p);
        case (p)
            M_GREEN:  return G * TD;
            M_YELLOW: return Y * TD;
            default:  return R * TD;
        endcase
    endfunction

    task automatic modelReset();
        m_state = M_IDLE;
        m_dir   = 0;
        m_el    = 0;
        m_grant = 1'b0;
        m_pend  = '0;
    endtask

    task automatic modelEnterGreen(input int d);
        m_state   = M_GREEN;
        m_dir     = d;
        m_el      = 0;
        m_grant   = m_pend[d];
        m_pend[d] = 1'b0;
    endtask

    // One clock edge of the model with the inputs seen at that edge.
    task automatic modelEdge(input logic start, input logic [N-1:0] ped);
        m_pend = m_pend | ped;
        if (m_state == M_IDLE) begin
            if (start) modelEnterGreen(0);
        end else begin
            m_el++;
            if (m_el == phaseCycles(m_state)) begin
                case (m_state)
                    M_GREEN: begin
                        m_state = M_YELLOW;
                        m_el    = 0;
                        m_grant = 1'b0;
                    end
                    M_YELLOW: begin
                        m_state = M_ALLRED;
                        m_el    = 0;
                    end
                    default: begin
                        if (start) begin
                            modelEnterGreen((m_dir + 1) % N);
                        end else begin
                            m_state = M_IDLE;
                            m_dir   = 0;
                            m_el    = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic expectedLamps(output logic [4*N-1:0] ct, output logic [2*N-1:0] wt);
        logic walk;
        ct = {N{4'b0001}};
        wt = {N{2'b01}};
        if (m_state == M_GREEN) begin
            ct[4*m_dir +: 4] = {(m_el < L * TD), 3'b100};
            if (m_grant) begin
                walk = 1'b1;
`ifdef PED_FLASH_EN
                if (m_el >= (G - FL) * TD) walk = (((m_el - (G - FL) * TD) / TD) % 2) == 1;
`endif
                wt[2*m_dir +: 2] = {walk, 1'b0};
            end
        end else if (m_state == M_YELLOW) begin
            ct[4*m_dir +: 4] = 4'b0010;
        end
    endtask

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then check
    // every output one time unit after the edge.
    task automatic applyStimulus(input logic start, input logic [N-1:0] ped);
        logic [4*N-1:0] exp_ct;
        logic [2*N-1:0] exp_wt;
        i_start   = start;
        i_ped_req = ped;
        @(posedge clk);
        modelEdge(start, ped);
        #1;
        expectedLamps(exp_ct, exp_wt);
        checkOutput("ct", 32'(o_ct), 32'(exp_ct));
        checkOutput("wt", 32'(o_wt), 32'(exp_wt));
        checkOutput("dir", 32'(o_dir), 32'(m_dir));
        checkOutput("busy", 32'(o_busy), 32'(m_state != M_IDLE));
    endtask

    // Main sequence: reset, directed run, mid-green reset, start drop, then
    // randomized traffic.
    initial begin
        logic         start;
        logic [N-1:0] ped;
        logic         found;

        reset_n   = 1'b0;
        i_start   = 1'b0;
        i_ped_req = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ct", 32'(o_ct), 32'h1111);
        checkOutput("rst_wt", 32'(o_wt), 32'h55);
        checkOutput("rst_busy", 32'(o_busy), 32'h0);
        checkOutput("rst_dir", 32'(o_dir), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        repeat (3) applyStimulus(1'b0, '0);

        // Start held; k = 0 is the green-entry edge for approach 0.
        // Requests for approaches 0 and 1 arrive during approach 0's green.
        for (int k = 0; k < 260; k++) begin
            ped = (k == 5) ? 4'b0011 : 4'b0000;
            applyStimulus(1'b1, ped);
            if (k == 30)  checkOutput("c30_dir1_walk", 32'(o_wt[3:2]), 32'h2);
            if (k == 50)  checkOutput("c50_dir1_yellow_wt", 32'(o_wt[3:2]), 32'h1);
            if (k == 119) checkOutput("c119_dir0_red", 32'(o_ct[3:0]), 32'h1);
            if (k == 120) checkOutput("c120_dir0_green", 32'({o_dir, o_ct[3:0]}), 32'h0C);
            if (k == 120) checkOutput("c120_dir0_walk", 32'(o_wt[1:0]), 32'h2);
        end

        // Latch a request for approach 3, then reset part-way through the
        // green of approach 2; the latch must not survive the reset.
        for (int i = 0; i < 200; i++) begin
            if (m_state == M_GREEN && m_dir == 2 && m_el == 5) break;
            ped = (i == 0) ? 4'b1000 : 4'b0000;
            applyStimulus(1'b1, ped);
        end
        found = (m_state == M_GREEN && m_dir == 2 && m_el == 5);
        checkOutput("reach_dir2_green", 32'(found), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midrst_ct", 32'(o_ct), 32'h1111);
        checkOutput("midrst_wt", 32'(o_wt), 32'h55);
        checkOutput("midrst_busy", 32'(o_busy), 32'h0);
        checkOutput("midrst_dir", 32'(o_dir), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Run to approach 3's yellow, then drop start there.
        for (int i = 0; i < 200; i++) begin
            if (m_state == M_YELLOW && m_dir == 3) break;
            applyStimulus(1'b1, '0);
        end
        found = (m_state == M_YELLOW && m_dir == 3);
        checkOutput("reach_dir3_yellow", 32'(found), 32'h1);
        repeat (15) applyStimulus(1'b0, '0);
        checkOutput("drop_idle_ct", 32'(o_ct), 32'h1111);
        checkOutput("drop_idle_busy", 32'(o_busy), 32'h0);
        checkOutput("drop_idle_dir", 32'(o_dir), 32'h0);

        // Randomized traffic, including requests on the green-entry edge.
        start = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) start = ~start;
            for (int b = 0; b < N; b++) ped[b] = ($urandom_range(0, 23) == 0);
            if (m_state == M_ALLRED && m_el == R * TD - 1 && $urandom_range(0, 1) == 1)
                ped[(m_dir + 1) % N] = 1'b1;
            applyStimulus(start, ped);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
